// File: rtl/stable_timer.sv
// Stable counter (rdcntvl/rdcntvh/rdcntid source) plus TCFG/TVAL/TICLR countdown timer.
// Optional STABLE_CNT_SNAPSHOT_EN: cnt_hi returns the high half latched by rd_lo_req.
module stable_timer #(
  parameter int          CNT_WIDTH   = 64,
  parameter int          TIMER_WIDTH = 32,
  parameter logic [31:0] COUNTER_ID  = 32'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cnt_stop,
  input  logic                     tcfg_we,
  input  logic [TIMER_WIDTH-1:0]   tcfg_wdata,
  input  logic                     ticlr_we,
  input  logic                     ticlr_wdata,
  input  logic                     rd_lo_req,
  output logic [CNT_WIDTH-1:0]     cnt,
  output logic [CNT_WIDTH/2-1:0]   cnt_hi,
  output logic [31:0]              counter_id,
  output logic [TIMER_WIDTH-1:0]   tcfg,
  output logic [TIMER_WIDTH-1:0]   tval,
  output logic                     timer_int
);

  localparam int HALF = CNT_WIDTH / 2;
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMER_WIDTH-1:0] TVAL_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

  // Reload value is InitVal scaled by four: {TCFG[W-1:2], 2'b00}.
  function automatic logic [TIMER_WIDTH-1:0] f_reload(input logic [TIMER_WIDTH-1:0] cfg);
    return {cfg[TIMER_WIDTH-1:2], 2'b00};
  endfunction

  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [TIMER_WIDTH-1:0] r_tcfg;
  logic [TIMER_WIDTH-1:0] r_tval;
  logic                   r_timer_en;
  logic                   r_timer_int;

  logic                   w_tick;
  logic                   w_expire;
  logic                   w_clr;
  logic                   w_periodic;
  logic [TIMER_WIDTH-1:0] w_reload;

  always_comb begin
    w_tick     = r_timer_en & ~cnt_stop;
    w_expire   = w_tick & (r_tval == '0);
    w_clr      = ticlr_we & ticlr_wdata;
    w_periodic = r_tcfg[1];
    w_reload   = f_reload(r_tcfg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!cnt_stop) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // A TCFG write overrides the tick for tval/timer_en, even on the expiry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcfg     <= '0;
      r_tval     <= '0;
      r_timer_en <= 1'b0;
    end else if (tcfg_we) begin
      r_tcfg     <= tcfg_wdata;
      r_tval     <= f_reload(tcfg_wdata);
      r_timer_en <= tcfg_wdata[0];
    end else if (w_tick) begin
      if (r_tval != '0) begin
        r_tval <= r_tval - TVAL_ONE;
      end else if (w_periodic) begin
        r_tval <= w_reload;
      end else begin
        r_timer_en <= 1'b0;
      end
    end
  end

  // Expiry takes priority over a simultaneous TICLR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer_int <= 1'b0;
    end else if (w_expire) begin
      r_timer_int <= 1'b1;
    end else if (w_clr) begin
      r_timer_int <= 1'b0;
    end
  end

`ifdef STABLE_CNT_SNAPSHOT_EN
  logic [HALF-1:0] r_snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
    end else if (rd_lo_req) begin
      r_snap <= r_cnt[CNT_WIDTH-1:HALF];
    end
  end

  assign cnt_hi = r_snap;
`else
  logic w_unused_rd_lo_req;
  assign w_unused_rd_lo_req = rd_lo_req;
  assign cnt_hi = r_cnt[CNT_WIDTH-1:HALF];
`endif

  assign cnt        = r_cnt;
  assign counter_id = COUNTER_ID;
  assign tcfg       = r_tcfg;
  assign tval       = r_tval;
  assign timer_int  = r_timer_int;

endmodule
